// File: rtl/game_over_screen.sv
// Game-over overlay: background fades in, an "L" glyph blinks, then the screen holds steady in DONE.
// pixel_out is registered one cycle after hcount_in/vcount_in; there is no backpressure.
module game_over_screen #(
  parameter int          SCREEN_WIDTH  = 1280,
  parameter int          SCREEN_HEIGHT = 720,
  parameter logic [23:0] BG_COLOR      = 24'h800000,
  parameter logic [23:0] FG_COLOR      = 24'hFFFFFF,
  parameter int          FADE_STEPS    = 8,
  parameter int          BLINK_FRAMES  = 30,
  parameter int          HOLD_FRAMES   = 180
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        new_frame_in,
  input  logic        start_in,
  output logic [23:0] pixel_out,
  output logic        done_out
);

  localparam int LOG2_FS = $clog2(FADE_STEPS);
  localparam int LW      = LOG2_FS + 1;
  localparam int PW      = 8 + LW;
  localparam int BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int HW      = $clog2(HOLD_FRAMES + 1);

  localparam logic [LW-1:0] FADE_LAST  = LW'(FADE_STEPS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);

  localparam logic [11:0] X_LO      = 12'(SCREEN_WIDTH * 45 / 100);
  localparam logic [11:0] X_BAR_HI  = 12'(SCREEN_WIDTH * 55 / 100);
  localparam logic [11:0] X_FOOT_HI = 12'(SCREEN_WIDTH * 75 / 100);
  localparam logic [10:0] Y_BAR_LO  = 11'(SCREEN_HEIGHT * 25 / 100);
  localparam logic [10:0] Y_FOOT_LO = 11'(SCREEN_HEIGHT * 60 / 100);
  localparam logic [10:0] Y_HI      = 11'(SCREEN_HEIGHT * 75 / 100);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FADE  = 2'd1;
  localparam logic [1:0] S_BLINK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          phase_q, phase_d;
  logic [23:0]   pixel_q, pixel_d;

  logic [11:0] h_ext;
  logic [10:0] v_ext;
  logic        active;
  logic        glyph;

  function automatic logic [7:0] fade_ch(input logic [7:0] c, input logic [LW-1:0] lvl);
    logic [PW-1:0] prod;
    prod = PW'(c) * PW'(lvl);
    return prod[LOG2_FS +: 8];
  endfunction

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    blink_d = blink_q;
    hold_d  = hold_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE: begin
        // start wins over a coincident frame pulse; nothing is counted here
        if (start_in) begin
          state_d = S_FADE;
          level_d = '0;
          blink_d = '0;
          hold_d  = '0;
          phase_d = 1'b1;
        end
      end
      S_FADE: begin
        if (new_frame_in) begin
          level_d = level_q + LW'(1);
          if (level_q == FADE_LAST) state_d = S_BLINK;
        end
      end
      S_BLINK: begin
        if (new_frame_in) begin
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + BW'(1);
          end
          hold_d = hold_q + HW'(1);
          if (hold_q == HOLD_LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign h_ext  = {1'b0, hcount_in};
  assign v_ext  = {1'b0, vcount_in};
  assign active = (h_ext < 12'(SCREEN_WIDTH)) && (v_ext < 11'(SCREEN_HEIGHT));
  assign glyph  = ((h_ext > X_LO) && (h_ext < X_BAR_HI)  && (v_ext > Y_BAR_LO)  && (v_ext < Y_HI)) ||
                  ((h_ext > X_LO) && (h_ext < X_FOOT_HI) && (v_ext > Y_FOOT_LO) && (v_ext < Y_HI));

  always_comb begin
    pixel_d = '0;
    if (active) begin
      case (state_q)
        S_FADE:  pixel_d = {fade_ch(BG_COLOR[23:16], level_q),
                            fade_ch(BG_COLOR[15:8],  level_q),
                            fade_ch(BG_COLOR[7:0],   level_q)};
        S_BLINK: pixel_d = (glyph && phase_q) ? FG_COLOR : BG_COLOR;
        S_DONE:  pixel_d = glyph ? FG_COLOR : BG_COLOR;
        default: pixel_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      level_q <= '0;
      blink_q <= '0;
      hold_q  <= '0;
      phase_q <= 1'b1;
      pixel_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      blink_q <= blink_d;
      hold_q  <= hold_d;
      phase_q <= phase_d;
      pixel_q <= pixel_d;
    end
  end

  assign pixel_out = pixel_q;
  assign done_out  = (state_q == S_DONE);

endmodule

// File: tb/tb_game_over_screen.sv
// Two instances (different blink/hold settings) share one stimulus stream; a scoreboard checks every cycle.
module tb_game_over_screen;

  localparam int          SW = 1280;
  localparam int          SH = 720;
  localparam int          FS = 8;
  localparam logic [23:0] BG = 24'h800000;
  localparam logic [23:0] FG = 24'hFFFFFF;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        new_frame_in;
  logic        start_in;
  logic [23:0] pixel_a, pixel_b;
  logic        done_a, done_b;

  game_over_screen #(.BLINK_FRAMES(2), .HOLD_FRAMES(6)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .new_frame_in(new_frame_in), .start_in(start_in), .pixel_out(pixel_a), .done_out(done_a));

  game_over_screen #(.BLINK_FRAMES(1), .HOLD_FRAMES(3)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .new_frame_in(new_frame_in), .start_in(start_in), .pixel_out(pixel_b), .done_out(done_b));

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [23:0] pa;
    logic [23:0] pb;
    logic        da;
    logic        db;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   blink_fr[2] = '{2, 1};
  int   hold_fr[2]  = '{6, 3};

  // Model state: whether a sequence is running and how many frame pulses it has seen.
  bit m_started = 1'b0;
  int m_n       = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int inst, input int h, input int v);
    logic [23:0] r;
    bit          g;
    int          b;
    if (!m_started || h >= SW || v >= SH) return 24'h0;
    g = (h > SW*45/100 && h < SW*55/100 && v > SH*25/100 && v < SH*75/100) ||
        (h > SW*45/100 && h < SW*75/100 && v > SH*60/100 && v < SH*75/100);
    if (m_n < FS) begin
      r = '0;
      for (int i = 0; i < 3; i++) r[8*i +: 8] = 8'(((int'(BG) >> (8*i)) & 255) * m_n / FS);
      return r;
    end
    b = m_n - FS;
    if (b >= hold_fr[inst]) return g ? FG : BG;
    return (g && ((b / blink_fr[inst]) % 2 == 0)) ? FG : BG;
  endfunction

  initial begin : model
    exp_t e;
    forever begin
      @(posedge clk_in);
      e = '0;
      if (rst_in) begin
        m_started = 1'b0;
        m_n       = 0;
      end else begin
        e.pa = exp_pix(0, int'(hcount_in), int'(vcount_in));
        e.pb = exp_pix(1, int'(hcount_in), int'(vcount_in));
        if (!m_started) begin
          if (start_in) begin
            m_started = 1'b1;
            m_n       = 0;
          end
        end else if (new_frame_in && m_n < 1000) begin
          m_n++;
        end
        e.da = m_started && (m_n >= FS + hold_fr[0]);
        e.db = m_started && (m_n >= FS + hold_fr[1]);
      end
      expq.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: got no expected entry, required one at %0t", $time);
      end else begin
        e = expq.pop_front();
        chk("sb_pix_a",  pixel_a, e.pa);
        chk("sb_pix_b",  pixel_b, e.pb);
        chk("sb_done_a", done_a,  e.da);
        chk("sb_done_b", done_b,  e.db);
      end
    end
  end

  function automatic int pick_h();
    int hl[12];
    hl = '{0, 575, 576, 577, 703, 704, 705, 959, 960, 961, 1279, 1280};
    case ($urandom_range(0, 3))
      0:       return hl[$urandom_range(0, 11)];
      1, 2:    return $urandom_range(560, 980);
      default: return $urandom_range(0, 1400);
    endcase
  endfunction

  function automatic int pick_v();
    int vl[11];
    vl = '{179, 180, 181, 431, 432, 433, 539, 540, 541, 719, 720};
    case ($urandom_range(0, 3))
      0:       return vl[$urandom_range(0, 10)];
      1, 2:    return $urandom_range(150, 560);
      default: return $urandom_range(0, 760);
    endcase
  endfunction

  task automatic cyc(input int h, input int v, input bit nf, input bit st);
    @(negedge clk_in);
    hcount_in    = 11'(h);
    vcount_in    = 10'(v);
    new_frame_in = nf;
    start_in     = st;
  endtask

  task automatic rnd_cyc(input bit allow_start);
    cyc(pick_h(), pick_v(), 1'b0, allow_start && ($urandom_range(0, 9) == 0));
  endtask

  // Drive one coordinate and wait until its registered pixel is visible.
  task automatic look(input int h, input int v);
    cyc(h, v, 1'b0, 1'b0);
    @(negedge clk_in);
  endtask

  task automatic run_frame(input bit allow_start);
    repeat (12) rnd_cyc(allow_start);
    cyc(pick_h(), pick_v(), 1'b1, allow_start && ($urandom_range(0, 3) == 0));
  endtask

  initial begin : driver
    int fr;
    rst_in = 1'b1; hcount_in = '0; vcount_in = '0; new_frame_in = 1'b0; start_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_pix_a", pixel_a, 0);
    chk("rst_done_b", done_b, 0);
    rst_in = 1'b0;

    repeat (150) cyc(pick_h(), pick_v(), $urandom_range(0, 9) == 0, 1'b0);
    look(640, 400);
    chk("idle_glyph_a", pixel_a, 0);
    chk("idle_done_a", done_a, 0);

    cyc(pick_h(), pick_v(), 1'b1, 1'b1);
    fr = 0;
    while (fr < 16) begin
      repeat (12) rnd_cyc(1'b1);
      if (fr == 4) begin
        look(0, 0);
        chk("fade4_corner_a", pixel_a, 32'h400000);
        look(640, 400);
        chk("fade4_glyph_a", pixel_a, 32'h400000);
      end
      if (fr >= 8 && fr <= 11) begin
        look(640, 400);
        chk("blink_glyph_a", pixel_a, (fr < 10) ? 32'hFFFFFF : 32'h800000);
        look(1000, 100);
        chk("blink_bg_a", pixel_a, 32'h800000);
      end
      if (fr == 10) chk("done_b_before", done_b, 0);
      if (fr == 11) chk("done_b_after", done_b, 1);
      cyc(pick_h(), pick_v(), 1'b1, $urandom_range(0, 3) == 0);
      fr++;
    end

    chk("done_a", done_a, 1);
    cyc(576, 400, 1'b0, 1'b0);
    cyc(577, 400, 1'b0, 1'b0);
    chk("edge_576_a", pixel_a, 32'h800000);
    @(negedge clk_in);
    chk("edge_577_a", pixel_a, 32'hFFFFFF);
    look(1300, 400);
    chk("oor_h_a", pixel_a, 0);
    look(640, 740);
    chk("oor_v_a", pixel_a, 0);
    cyc(640, 400, 1'b0, 1'b1);
    repeat (10) rnd_cyc(1'b1);

    @(negedge clk_in); rst_in = 1'b1;
    @(negedge clk_in); rst_in = 1'b0;
    repeat (20) cyc(pick_h(), pick_v(), $urandom_range(0, 5) == 0, 1'b0);
    look(640, 400);
    chk("post_rst_idle_a", pixel_a, 0);

    cyc(pick_h(), pick_v(), 1'b0, 1'b1);
    repeat (3) run_frame(1'b1);
    look(0, 0);
    chk("fade3_corner_a", pixel_a, 32'h300000);
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    chk("async_rst_pix_a", pixel_a, 0);
    chk("async_rst_pix_b", pixel_b, 0);
    @(negedge clk_in); rst_in = 1'b0;
    repeat (30) cyc(pick_h(), pick_v(), $urandom_range(0, 5) == 0, 1'b0);
    look(640, 400);
    chk("rst_abandon_a", pixel_a, 0);

    cyc(pick_h(), pick_v(), 1'b0, 1'b1);
    repeat (10) run_frame(1'b1);
    repeat (20) rnd_cyc(1'b1);
    repeat (3) @(negedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_over_screen.md
GAME_OVER_SCREEN -- requirements
Module: game_over_screen

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 1280, giving the active width in pixels.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 720, giving the active height in pixels.
REQ-003 SHALL have parameter BG_COLOR, default 24'h800000, giving the full-intensity background RGB.
REQ-004 SHALL have parameter FG_COLOR, default 24'hFFFFFF, giving the glyph RGB.
REQ-005 SHALL have parameter FADE_STEPS, default 8, a power of two from 2 to 64, giving the number of fade frames.
REQ-006 SHALL have parameter BLINK_FRAMES, default 30, giving the number of frames per glyph on/off phase (minimum 1).
REQ-007 SHALL have parameter HOLD_FRAMES, default 180, giving the number of frames spent blinking before the done state (minimum 1).
REQ-008 SHALL have port clk_in, input, 1 bit: the pixel clock, and the only clock.
REQ-009 SHALL have port rst_in, input, 1 bit: asynchronous, active-high reset.
REQ-010 SHALL have port hcount_in, input, 11 bits: horizontal pixel position.
REQ-011 SHALL have port vcount_in, input, 10 bits: vertical pixel position.
REQ-012 SHALL have port new_frame_in, input, 1 bit: a single-cycle pulse at the start of each frame.
REQ-013 SHALL have port start_in, input, 1 bit: a single-cycle pulse that triggers the game-over sequence.
REQ-014 SHALL have port pixel_out, output, 24 bits: registered RGB.
REQ-015 SHALL have port done_out, output, 1 bit: high while in the DONE state.

Function
REQ-016 SHALL implement the states IDLE, FADE, BLINK and DONE.
REQ-017 SHALL move from IDLE to FADE on start_in, clearing the fade level, blink counter, hold counter and blink phase (phase = on).
REQ-018 SHALL, in FADE, increment the fade level on each new_frame_in, and move to BLINK on the new_frame_in that takes the level to FADE_STEPS.
REQ-019 SHALL, in BLINK, increment the blink counter on each new_frame_in; when it reaches BLINK_FRAMES-1 it SHALL wrap to 0 and toggle the phase.
REQ-020 SHALL, in BLINK, increment the hold counter on each new_frame_in, and move to DONE on the new_frame_in that takes it to HOLD_FRAMES.
REQ-021 SHALL remain in DONE until reset, with done_out=1, the glyph steady on and the background at full intensity.
REQ-022 SHALL ignore start_in outside IDLE.
REQ-023 SHALL, in IDLE, ignore new_frame_in when it coincides with start_in; start_in takes priority and no level is counted.
REQ-024 SHALL define active as hcount_in < SCREEN_WIDTH and vcount_in < SCREEN_HEIGHT.
REQ-025 SHALL define the glyph (an "L" shape) as the union of two regions, with all strict inequalities and the bounds computed with integer arithmetic at elaboration:
- bar: SW*45/100 < h < SW*55/100, SH*25/100 < v < SH*75/100
- foot: SW*45/100 < h < SW*75/100, SH*60/100 < v < SH*75/100
REQ-026 SHALL compute the fade background for each 8-bit channel c of BG_COLOR as (c*level) >> log2(FADE_STEPS), using a product width of at least 8+log2(FADE_STEPS)+1 bits, truncated to 8 bits.
REQ-027 SHALL produce pixel_out as follows:
- inactive pixel: 0
- IDLE: 0
- FADE: the fade background, with no glyph
- BLINK: FG_COLOR if glyph and phase on, else BG_COLOR
- DONE: FG_COLOR if glyph, else BG_COLOR
REQ-028 SHALL register pixel_out so that it reflects the hcount_in, vcount_in and state sampled on the previous clock edge (latency exactly 1 cycle).
REQ-029 SHALL make a state change on a new_frame_in edge visible in pixel_out starting with the following cycle's pixel.

Reset
REQ-030 SHALL, while rst_in=1, asynchronously force the state to IDLE, all counters and the fade level to 0, the phase to on, pixel_out=0 and done_out=0.
REQ-031 SHALL, on a reset asserted mid-sequence, abandon the sequence; after rst_in is released the block SHALL wait in IDLE for a new start_in.

Verification
REQ-032 SHALL cover reset then idle: apply rst_in, then sweep a frame with no start_in -> pixel_out=0 at every pixel and done_out=0.
REQ-033 SHALL cover the fade: defaults, start_in, then 4 new_frame_in pulses -> pixel (0,0) = 24'h400000 and glyph pixel (640,400) = 24'h400000; after 8 pulses the state is BLINK.
REQ-034 SHALL cover the blink, with BLINK_FRAMES=2:
- after fade completion, pixel (640,400) shows FFFFFF for frames 0-1 and 800000 for frames 2-3
- pixel (1000,100) stays 800000 throughout
REQ-035 SHALL cover done and latency: HOLD_FRAMES=3 -> done_out rises on the 3rd BLINK frame pulse; pixel_out lags hcount_in by exactly 1 cycle at the glyph edge h=577 vs 576.
REQ-036 SHALL cover restart and reset: start_in in BLINK -> no effect; rst_in asserted in FADE -> pixel_out=0 immediately, without waiting for a clock edge.
REQ-037 SHALL cover out-of-range counts: hcount_in=1300 or vcount_in=740 in DONE -> pixel_out=0.
